// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact occupancy, threshold flags,
// registered read strobe and sticky overflow/underflow errors.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             n_we_i,
    input  logic             n_re_i,
    input  logic             n_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             p_valid_o,
    output logic [15:0]      level_o,
    output logic             p_empty_o,
    output logic             p_full_o,
    output logic             p_aempty_o,
    output logic             p_afull_o,
    output logic             p_ovf_o,
    output logic             p_udf_o
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);
    localparam logic [15:0]     DEPTH_L  = 16'(DEPTH);
    localparam logic [15:0]     AFULL_L  = 16'(AFULL_TH);
    localparam logic [15:0]     AEMPTY_L = 16'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [15:0]      level;
    logic             rd_req, wr_req, rd_ok, wr_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign rd_req = !n_re_i;
    assign wr_req = !n_we_i;
    assign rd_ok  = rd_req && (level != 16'd0);
    // A write at full is still accepted when a read frees a slot this cycle.
    assign wr_ok  = wr_req && ((level != DEPTH_L) || rd_ok);

    // Storage is not reset; at full rd_ptr == wr_ptr, and the read below
    // samples the old word because both sides update on the same edge.
    always_ff @(posedge clk) begin
        if (wr_ok && n_clr_i)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            data_o    <= '0;
            p_valid_o <= 1'b0;
            p_ovf_o   <= 1'b0;
            p_udf_o   <= 1'b0;
        end else if (!n_clr_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            data_o    <= '0;
            p_valid_o <= 1'b0;
            p_ovf_o   <= 1'b0;
            p_udf_o   <= 1'b0;
        end else begin
            p_valid_o <= rd_ok;
            if (rd_ok) begin
                data_o <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            level <= 16'({1'b0, level} + 17'(wr_ok) - 17'(rd_ok));
            if (wr_req && !wr_ok)
                p_ovf_o <= 1'b1;
            if (rd_req && (level == 16'd0))
                p_udf_o <= 1'b1;
        end
    end

    assign level_o    = level;
    assign p_empty_o  = (level == 16'd0);
    assign p_full_o   = (level == DEPTH_L);
    assign p_aempty_o = (level <= AEMPTY_L);
    assign p_afull_o  = (level >= AFULL_L);

endmodule
